// File: rtl/spi_frame_pkg.sv
// Shared types and helpers for the serial frame loader.
package spi_frame_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StHdr,
        StWdata,
        StWcommit,
        StRfetch,
        StRshift,
        StDrain
    } state_t;

    localparam logic CMD_WRITE = 1'b1;
    localparam logic CMD_READ  = 1'b0;

    // Total bits in one frame: command + address + data.
    function automatic int unsigned frame_w(input int unsigned addr_w,
                                            input int unsigned data_w);
        return 1 + addr_w + data_w;
    endfunction

    // Ceiling log2, never below 1 so single-target builds still get a legal index width.
    function automatic int unsigned clog2(input int unsigned n);
        int unsigned r;
        r = 1;
        while ((32'd1 << r) < n) begin
            r++;
        end
        return r;
    endfunction

endpackage

// File: rtl/serial_shifter.sv
// MSB-first shift register with parallel load; load has priority over shift.
module serial_shifter #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] din,
    input  logic         shift,
    input  logic         sin,
    output logic         sout,
    output logic [W-1:0] q
);

    // Parallel load or shift one place toward the MSB.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= '0;
        end else if (load) begin
            q <= din;
        end else if (shift) begin
            q <= {q[W-2:0], sin};
        end
    end

    assign sout = q[W-1];

endmodule

// File: rtl/spi_frame_loader.sv
// Serial slave that writes and reads back target memories from an external master.
module spi_frame_loader
    import spi_frame_pkg::*;
#(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned ADDR_W = 4,
    parameter int unsigned N_TGT  = 3,
    parameter int unsigned TGT_W  = clog2(N_TGT)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              bit_en,
    input  logic [N_TGT-1:0]  cs_n,
    input  logic              mosi,
    output logic              miso,
    output logic              miso_oe,
    output logic              wr_valid,
    input  logic              wr_ready,
    output logic [TGT_W-1:0]  wr_tgt,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic              rd_req,
    output logic [TGT_W-1:0]  rd_tgt,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [DATA_W-1:0] rd_data,
    output logic              busy,
    output logic              err_abort,
    output logic              err_overrun,
    input  logic              clr_err
);

    localparam int unsigned RX_W    = ADDR_W + DATA_W;
    localparam int unsigned CNT_MAX = (ADDR_W + 1 > DATA_W) ? ADDR_W + 1 : DATA_W;
    localparam int unsigned CNT_W   = clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] ADDR_LAST = CNT_W'(ADDR_W - 1);
    localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_W - 1);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [TGT_W-1:0] tgt;
    logic             cmd;

    logic [TGT_W-1:0] sel_idx;
    int unsigned      low_cnt;
    logic             all_high;
    logic             released;
    logic             rx_shift;
    logic             tx_load;
    logic             tx_shift;
    logic             tx_msb;
    logic [RX_W-1:0]  rx_q;
    logic             unused_rx_sout;
    logic [DATA_W-1:0] unused_tx_q;

    // Count low chip selects and remember which one is low.
    always_comb begin
        sel_idx = '0;
        low_cnt = 0;
        for (int unsigned i = 0; i < N_TGT; i++) begin
            if (!cs_n[i]) begin
                sel_idx = TGT_W'(i);
                low_cnt++;
            end
        end
    end

    assign all_high = &cs_n;
    // The frame's own chip select going high ends the frame.
    assign released = cs_n[tgt];

    // Shift enables for the receive and transmit registers.
    always_comb begin
        rx_shift = bit_en && !released && ((state == StHdr) || (state == StWdata));
        tx_load  = (state == StRfetch) && !released && (cnt == CNT_W'(1));
        tx_shift = (state == StRshift) && !released && bit_en;
    end

    // Frame sequencer with registered handshake, strobe and error outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= StIdle;
            cnt         <= '0;
            tgt         <= '0;
            cmd         <= 1'b0;
            wr_valid    <= 1'b0;
            rd_req      <= 1'b0;
            miso_oe     <= 1'b0;
            err_abort   <= 1'b0;
            err_overrun <= 1'b0;
        end else begin
            rd_req <= 1'b0;
            // Later set assignments override the clear, so a new error wins.
            if (clr_err) begin
                err_abort   <= 1'b0;
                err_overrun <= 1'b0;
            end
            unique case (state)
                StIdle: begin
                    if (bit_en) begin
                        if (low_cnt == 1) begin
                            state <= StHdr;
                            cnt   <= '0;
                            tgt   <= sel_idx;
                            cmd   <= mosi;
                        end else if (low_cnt > 1) begin
                            err_overrun <= 1'b1;
                        end
                    end
                end
                StHdr: begin
                    if (released) begin
                        state     <= StIdle;
                        cnt       <= '0;
                        err_abort <= 1'b1;
                    end else if (bit_en) begin
                        if (cnt == ADDR_LAST) begin
                            cnt <= '0;
                            if (cmd == CMD_WRITE) begin
                                state <= StWdata;
                            end else begin
                                state  <= StRfetch;
                                rd_req <= 1'b1;
                            end
                        end else begin
                            cnt <= cnt + CNT_W'(1);
                        end
                    end
                end
                StWdata: begin
                    if (released) begin
                        state     <= StIdle;
                        cnt       <= '0;
                        err_abort <= 1'b1;
                    end else if (bit_en) begin
                        if (cnt == DATA_LAST) begin
                            state    <= StWcommit;
                            cnt      <= '0;
                            wr_valid <= 1'b1;
                        end else begin
                            cnt <= cnt + CNT_W'(1);
                        end
                    end
                end
                StWcommit: begin
                    // The frame is complete, so a released cs does not cancel the write.
                    if (bit_en && !all_high) begin
                        err_overrun <= 1'b1;
                    end
                    if (wr_valid && wr_ready) begin
                        wr_valid <= 1'b0;
                        state    <= all_high ? StIdle : StDrain;
                    end
                end
                StRfetch: begin
                    if (released) begin
                        state     <= StIdle;
                        cnt       <= '0;
                        err_abort <= 1'b1;
                    end else begin
                        if (bit_en) begin
                            err_overrun <= 1'b1;
                        end
                        // cnt 0: rd_req cycle; cnt 1: rd_data valid, loaded into tx.
                        if (cnt == CNT_W'(1)) begin
                            state   <= StRshift;
                            cnt     <= '0;
                            miso_oe <= 1'b1;
                        end else begin
                            cnt <= cnt + CNT_W'(1);
                        end
                    end
                end
                StRshift: begin
                    if (released) begin
                        state     <= StIdle;
                        cnt       <= '0;
                        miso_oe   <= 1'b0;
                        err_abort <= 1'b1;
                    end else if (bit_en) begin
                        if (cnt == DATA_LAST) begin
                            state   <= StDrain;
                            cnt     <= '0;
                            miso_oe <= 1'b0;
                        end else begin
                            cnt <= cnt + CNT_W'(1);
                        end
                    end
                end
                StDrain: begin
                    if (all_high) begin
                        state <= StIdle;
                    end
                end
                default: begin
                    state <= StIdle;
                    cnt   <= '0;
                end
            endcase
        end
    end

    serial_shifter #(
        .W(RX_W)
    ) u_rx (
        .clk  (clk),
        .rst_n(rst_n),
        .load (1'b0),
        .din  ('0),
        .shift(rx_shift),
        .sin  (mosi),
        .sout (unused_rx_sout),
        .q    (rx_q)
    );

    serial_shifter #(
        .W(DATA_W)
    ) u_tx (
        .clk  (clk),
        .rst_n(rst_n),
        .load (tx_load),
        .din  (rd_data),
        .shift(tx_shift),
        .sin  (1'b0),
        .sout (tx_msb),
        .q    (unused_tx_q)
    );

    assign miso    = miso_oe & tx_msb;
    assign busy    = (state != StIdle);
    assign wr_tgt  = tgt;
    assign rd_tgt  = tgt;
    assign wr_addr = rx_q[RX_W-1 -: ADDR_W];
    assign wr_data = rx_q[DATA_W-1:0];
    assign rd_addr = rx_q[ADDR_W-1:0];

endmodule

// File: tb/tb_spi_frame_loader.sv
// Directed bench for spi_frame_loader with a transaction-level scoreboard.
module tb_spi_frame_loader;
    import spi_frame_pkg::*;

    logic       clk;
    logic       rst_n;
    logic       bit_en;
    logic [2:0] cs_n;
    logic       mosi;
    logic       miso;
    logic       miso_oe;
    logic       wr_valid;
    logic       wr_ready;
    logic [1:0] wr_tgt;
    logic [3:0] wr_addr;
    logic [7:0] wr_data;
    logic       rd_req;
    logic [1:0] rd_tgt;
    logic [3:0] rd_addr;
    logic [7:0] rd_data;
    logic       busy;
    logic       err_abort;
    logic       err_overrun;
    logic       clr_err;

    spi_frame_loader #(
        .DATA_W(8),
        .ADDR_W(4),
        .N_TGT (3)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bit_en     (bit_en),
        .cs_n       (cs_n),
        .mosi       (mosi),
        .miso       (miso),
        .miso_oe    (miso_oe),
        .wr_valid   (wr_valid),
        .wr_ready   (wr_ready),
        .wr_tgt     (wr_tgt),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .rd_req     (rd_req),
        .rd_tgt     (rd_tgt),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .busy       (busy),
        .err_abort  (err_abort),
        .err_overrun(err_overrun),
        .clr_err    (clr_err)
    );

    typedef struct {
        logic [1:0] tgt;
        logic [3:0] addr;
        logic [7:0] data;
    } wr_t;

    typedef struct {
        logic [1:0] tgt;
        logic [3:0] addr;
    } rd_t;

    // Scoreboard: expected write/read transactions and MISO bit stream.
    wr_t  exp_wr[$];
    rd_t  exp_rd[$];
    logic exp_miso[$];

    int   n_checks = 0;
    int   n_err    = 0;
    int   n_accept = 0;
    int   n_rd     = 0;
    int   vrun     = 0;
    int   last_run = 0;
    logic prev_rd  = 1'b0;
    logic [7:0] miso_seq = 8'h00;
    logic [3:0] last_wr_addr = 4'h0;
    logic [7:0] last_wr_data = 8'h00;
    logic [1:0] last_wr_tgt  = 2'h0;
    logic [3:0] last_rd_addr = 4'h0;
    logic [7:0] rd_value = 8'h00;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    // Read responder: data appears exactly one cycle after rd_req, then is trashed.
    initial begin
        rd_data = 8'hFF;
        forever begin
            @(negedge clk);
            if (rd_req) begin
                @(posedge clk);
                #1 rd_data = rd_value;
                @(posedge clk);
                #1 rd_data = 8'hFF;
            end
        end
    end

    // Compare process: checks every meaningful output cycle against the scoreboard.
    always @(negedge clk) begin
        if (rst_n) begin
            if (wr_valid) begin
                vrun++;
                if (exp_wr.size() == 0) begin
                    check("spurious_wr_valid", 32'(wr_valid), 32'd0);
                end else begin
                    check("wr_tgt", 32'(wr_tgt), 32'(exp_wr[0].tgt));
                    check("wr_addr", 32'(wr_addr), 32'(exp_wr[0].addr));
                    check("wr_data", 32'(wr_data), 32'(exp_wr[0].data));
                    if (wr_ready) begin
                        void'(exp_wr.pop_front());
                        n_accept++;
                        last_wr_tgt  = wr_tgt;
                        last_wr_addr = wr_addr;
                        last_wr_data = wr_data;
                    end
                end
            end else if (vrun != 0) begin
                last_run = vrun;
                vrun     = 0;
            end
            if (rd_req) begin
                n_rd++;
                check("rd_req_single", 32'(prev_rd), 32'd0);
                if (exp_rd.size() == 0) begin
                    check("spurious_rd_req", 32'(rd_req), 32'd0);
                end else begin
                    check("rd_tgt", 32'(rd_tgt), 32'(exp_rd[0].tgt));
                    check("rd_addr", 32'(rd_addr), 32'(exp_rd[0].addr));
                    last_rd_addr = rd_addr;
                    void'(exp_rd.pop_front());
                end
            end
            prev_rd = rd_req;
            if (miso_oe) begin
                if (exp_miso.size() == 0) begin
                    check("spurious_miso_oe", 32'(miso_oe), 32'd0);
                end else begin
                    check("miso_bit", 32'(miso), 32'(exp_miso[0]));
                    if (bit_en) begin
                        miso_seq = {miso_seq[6:0], miso};
                        void'(exp_miso.pop_front());
                    end
                end
            end
        end else begin
            vrun    = 0;
            prev_rd = 1'b0;
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // One strobe followed by one idle clock.
    task automatic send_bit(input logic b);
        mosi   = b;
        bit_en = 1'b1;
        tick(1);
        bit_en = 1'b0;
        tick(1);
    endtask

    task automatic send_bits(input logic [7:0] v, input int n);
        for (int i = n - 1; i >= 0; i--) begin
            send_bit(v[i]);
        end
    endtask

    task automatic write_frame(input logic [2:0] c, input logic [3:0] a, input logic [7:0] d);
        cs_n = c;
        tick(1);
        send_bit(CMD_WRITE);
        send_bits({4'h0, a}, 4);
        send_bits(d, 8);
    endtask

    task automatic push_wr(input logic [1:0] t, input logic [3:0] a, input logic [7:0] d);
        wr_t e;
        e.tgt  = t;
        e.addr = a;
        e.data = d;
        exp_wr.push_back(e);
    endtask

    // Read header plus data strobes; strobes start three clocks after the last address bit.
    task automatic read_frame(input logic [2:0] c, input logic [1:0] t, input logic [3:0] a,
                              input logic [7:0] v, input int strobes);
        rd_t e;
        e.tgt  = t;
        e.addr = a;
        exp_rd.push_back(e);
        for (int i = 7; i >= 0; i--) begin
            exp_miso.push_back(v[i]);
        end
        rd_value = v;
        cs_n     = c;
        tick(1);
        send_bit(CMD_READ);
        send_bits({4'h0, a}, 4);
        tick(1);
        for (int i = 0; i < strobes; i++) begin
            send_bit(1'b1);
        end
    endtask

    task automatic clear_errors();
        clr_err = 1'b1;
        tick(1);
        clr_err = 1'b0;
    endtask

    int acc0;
    int rd0;

    initial begin
        rst_n    = 1'b0;
        bit_en   = 1'b0;
        cs_n     = 3'b111;
        mosi     = 1'b0;
        wr_ready = 1'b1;
        clr_err  = 1'b0;
        tick(3);
        rst_n = 1'b1;
        tick(1);

        // Reset state
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_miso_oe", 32'(miso_oe), 32'd0);
        check("reset_wr_valid", 32'(wr_valid), 32'd0);
        check("reset_rd_req", 32'(rd_req), 32'd0);
        check("reset_err_abort", 32'(err_abort), 32'd0);
        check("reset_err_overrun", 32'(err_overrun), 32'd0);

        // Plain write to target 1
        acc0 = n_accept;
        push_wr(2'd1, 4'h5, 8'hA7);
        write_frame(3'b101, 4'h5, 8'hA7);
        check("wr_accept_count", 32'(n_accept - acc0), 32'd1);
        check("wr_lit_tgt", 32'(last_wr_tgt), 32'd1);
        check("wr_lit_addr", 32'(last_wr_addr), 32'h5);
        check("wr_lit_data", 32'(last_wr_data), 32'hA7);
        check("wr_busy_in_drain", 32'(busy), 32'd1);
        cs_n = 3'b111;
        tick(2);
        check("wr_busy_after_release", 32'(busy), 32'd0);
        check("wr_valid_run", 32'(last_run), 32'd1);
        check("wr_no_overrun", 32'(err_overrun), 32'd0);
        check("wr_no_abort", 32'(err_abort), 32'd0);

        // Backpressure: ready low for four valid cycles, one stray strobe while waiting
        acc0     = n_accept;
        wr_ready = 1'b0;
        push_wr(2'd1, 4'h5, 8'hA7);
        write_frame(3'b101, 4'h5, 8'hA7);
        bit_en = 1'b1;
        mosi   = 1'b1;
        tick(1);
        bit_en = 1'b0;
        tick(2);
        wr_ready = 1'b1;
        tick(2);
        check("bp_valid_run", 32'(last_run), 32'd5);
        check("bp_accept_count", 32'(n_accept - acc0), 32'd1);
        check("bp_overrun", 32'(err_overrun), 32'd1);
        check("bp_lit_data", 32'(last_wr_data), 32'hA7);
        cs_n = 3'b111;
        tick(2);
        clear_errors();

        // Read from target 0, address 0xC
        rd0 = n_rd;
        read_frame(3'b110, 2'd0, 4'hC, 8'h3C, 8);
        tick(1);
        check("rd_pulse_count", 32'(n_rd - rd0), 32'd1);
        check("rd_lit_addr", 32'(last_rd_addr), 32'hC);
        check("rd_miso_seq", 32'(miso_seq), 32'h3C);
        check("rd_miso_oe_off", 32'(miso_oe), 32'd0);
        check("rd_miso_drained", 32'(exp_miso.size()), 32'd0);
        check("rd_no_overrun", 32'(err_overrun), 32'd0);
        cs_n = 3'b111;
        tick(2);
        check("rd_busy_after", 32'(busy), 32'd0);

        // Abort after seven bits
        cs_n = 3'b011;
        tick(1);
        send_bit(CMD_WRITE);
        send_bits(8'h03, 4);
        send_bits(8'h02, 2);
        cs_n = 3'b111;
        tick(1);
        check("abort_flag", 32'(err_abort), 32'd1);
        check("abort_busy", 32'(busy), 32'd0);
        clear_errors();
        check("clr_abort", 32'(err_abort), 32'd0);
        check("clr_overrun", 32'(err_overrun), 32'd0);
        acc0 = n_accept;
        push_wr(2'd2, 4'h3, 8'h5A);
        write_frame(3'b011, 4'h3, 8'h5A);
        cs_n = 3'b111;
        tick(2);
        check("post_abort_accept", 32'(n_accept - acc0), 32'd1);
        check("post_abort_lit_tgt", 32'(last_wr_tgt), 32'd2);

        // Two chip selects low
        cs_n = 3'b100;
        tick(1);
        send_bit(1'b1);
        check("illegal_cs_overrun", 32'(err_overrun), 32'd1);
        check("illegal_cs_busy", 32'(busy), 32'd0);
        cs_n = 3'b111;
        tick(1);
        clear_errors();

        // Extra strobes after a complete write are ignored
        acc0 = n_accept;
        push_wr(2'd0, 4'h9, 8'hC3);
        write_frame(3'b110, 4'h9, 8'hC3);
        send_bits(8'h07, 3);
        check("extra_busy", 32'(busy), 32'd1);
        cs_n = 3'b111;
        tick(2);
        check("extra_accept_count", 32'(n_accept - acc0), 32'd1);
        check("extra_no_overrun", 32'(err_overrun), 32'd0);
        check("extra_busy_after", 32'(busy), 32'd0);

        // Reset in the middle of a read data phase
        read_frame(3'b101, 2'd1, 4'h2, 8'h81, 2);
        check("pre_reset_miso_oe", 32'(miso_oe), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("rst_miso_oe", 32'(miso_oe), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_rd_req", 32'(rd_req), 32'd0);
        check("rst_wr_valid", 32'(wr_valid), 32'd0);
        exp_miso.delete();
        cs_n = 3'b111;
        tick(1);
        rst_n = 1'b1;
        tick(2);
        check("post_rst_busy", 32'(busy), 32'd0);
        check("post_rst_miso_oe", 32'(miso_oe), 32'd0);

        check("wr_queue_empty", 32'(exp_wr.size()), 32'd0);
        check("rd_queue_empty", 32'(exp_rd.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
